// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bram_port_arbiter_if
// Brief  : Requester-side bundle of the shared BRAM port arbiter: per-requester
//          request/lock/address/byte-enable/write-data, plus grant and tagged
//          read-return signals.
// Rev    : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    lock;
   logic [NREQ*32-1:0] addr;
   logic [NREQ*4-1:0]  we;
   logic [NREQ*32-1:0] din;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [31:0]        rdata;

   // Requesters (engines) drive the access fields and receive grant/return.
   modport master (
      output req, lock, addr, we, din,
      input  gnt, rvalid, rdata
   );

   // The arbiter consumes the access fields and produces grant/return.
   modport slave (
      input  req, lock, addr, we, din,
      output gnt, rvalid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bram_port_arbiter
// Brief  : Shares one 32-bit BRAM port among NREQ requesters. Round-robin
//          arbitration with optional burst lock; read data is returned
//          READ_LAT cycles after issue, tagged to the issuing requester.
// Rev    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
   parameter int NREQ     = 3,
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   bram_port_arbiter_if.slave bus,
   output logic [31:0] BRAM_ADDR,
   output logic [3:0]  BRAM_WE,
   output logic        BRAM_EN,
   output logic [31:0] BRAM_DIN,
   output logic        BRAM_RST,
   input  logic [31:0] BRAM_DOUT
);

   localparam int            IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
   localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic            locked;

   logic [NREQ-1:0] gnt_vec;
   logic [IW-1:0]   gnt_idx;
   logic            any_gnt;
   logic [IW:0]     scan_sum;

   logic [READ_LAT-1:0] pipe_v;
   logic [IW-1:0]       pipe_id [READ_LAT];
   logic [NREQ-1:0]     rvalid_vec;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (i == LAST) ? '0 : i + 1'b1;
   endfunction

   // Grant selection: a locked owner keeps the port while it requests,
   // otherwise the first requester at or after rr_ptr wins.
   always_comb begin
      gnt_vec  = '0;
      gnt_idx  = '0;
      any_gnt  = 1'b0;
      scan_sum = '0;
      if (locked) begin
         gnt_vec[owner] = bus.req[owner];
         gnt_idx        = owner;
         any_gnt        = bus.req[owner];
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_sum >= NREQ_W) begin
               scan_sum = scan_sum - NREQ_W;
            end
            if (!any_gnt && bus.req[scan_sum[IW-1:0]]) begin
               gnt_vec[scan_sum[IW-1:0]] = 1'b1;
               gnt_idx                   = scan_sum[IW-1:0];
               any_gnt                   = 1'b1;
            end
         end
      end
      if (rst) begin
         gnt_vec = '0;
         any_gnt = 1'b0;
      end
   end

   // Port mux: steer the granted requester's slice onto the BRAM port.
   always_comb begin
      BRAM_ADDR = '0;
      BRAM_WE   = '0;
      BRAM_DIN  = '0;
      BRAM_EN   = any_gnt;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_vec[i]) begin
            BRAM_ADDR = bus.addr[32*i +: 32];
            BRAM_WE   = bus.we[4*i +: 4];
            BRAM_DIN  = bus.din[32*i +: 32];
         end
      end
   end

   // Arbitration state: remember owner/lock on each access; a locked owner
   // that stops requesting releases the lock and passes priority onward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
         owner  <= '0;
         locked <= 1'b0;
      end else if (any_gnt) begin
         owner  <= gnt_idx;
         locked <= bus.lock[gnt_idx];
         if (!bus.lock[gnt_idx]) begin
            rr_ptr <= next_idx(gnt_idx);
         end
      end else if (locked) begin
         locked <= 1'b0;
         rr_ptr <= next_idx(owner);
      end
   end

   // Read-return pipeline: tag each read with its requester id and shift it
   // along so the tag emerges alongside the BRAM output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
         for (int k = 0; k < READ_LAT; k++) begin
            pipe_id[k] <= '0;
         end
      end else begin
         pipe_v[0]  <= any_gnt && (BRAM_WE == 4'b0000);
         pipe_id[0] <= gnt_idx;
         for (int k = 1; k < READ_LAT; k++) begin
            pipe_v[k]  <= pipe_v[k-1];
            pipe_id[k] <= pipe_id[k-1];
         end
      end
   end

   // Decode the oldest pipeline tag into a one-hot read-valid.
   always_comb begin
      rvalid_vec = '0;
      if (pipe_v[READ_LAT-1] && !rst) begin
         rvalid_vec[pipe_id[READ_LAT-1]] = 1'b1;
      end
   end

   assign bus.gnt    = gnt_vec;
   assign bus.rvalid = rvalid_vec;
   assign bus.rdata  = BRAM_DOUT;
   assign BRAM_RST   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_port_arbiter
// Brief  : Bench for bram_port_arbiter: directed scenarios followed by random
//          traffic, with a reference arbiter/memory model feeding a read
//          scoreboard that an independent monitor drains.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

   localparam int NREQ     = 3;
   localparam int READ_LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] BRAM_ADDR;
   logic [3:0]  BRAM_WE;
   logic        BRAM_EN;
   logic [31:0] BRAM_DIN;
   logic        BRAM_RST;
   logic [31:0] BRAM_DOUT;

   bram_port_arbiter_if #(.NREQ(NREQ)) bus ();

   bram_port_arbiter #(.NREQ(NREQ), .READ_LAT(READ_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .BRAM_ADDR (BRAM_ADDR),
      .BRAM_WE   (BRAM_WE),
      .BRAM_EN   (BRAM_EN),
      .BRAM_DIN  (BRAM_DIN),
      .BRAM_RST  (BRAM_RST),
      .BRAM_DOUT (BRAM_DOUT)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment BRAM: one-cycle registered read, byte-enabled write.
   logic [31:0] bram_mem [64];
   always @(posedge clk) begin
      if (BRAM_EN) begin
         if (BRAM_WE == 4'b0000) begin
            BRAM_DOUT <= bram_mem[BRAM_ADDR[7:2]];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (BRAM_WE[b]) bram_mem[BRAM_ADDR[7:2]][8*b +: 8] <= BRAM_DIN[8*b +: 8];
            end
         end
      end
   end

   // Reference model state
   logic [31:0] ref_mem [64];
   int m_rr, m_owner;
   bit m_locked;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb [$];

   int checks   = 0;
   int failures = 0;

   logic [31:0] t_addr [NREQ];
   logic [3:0]  t_we   [NREQ];
   logic [31:0] t_din  [NREQ];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_rr = 0;
      m_owner = 0;
      m_locked = 0;
   endtask

   // Winner according to the arbitration rules, -1 when nobody is granted.
   function automatic int model_pick(input logic [NREQ-1:0] r);
      if (m_locked) return r[m_owner] ? m_owner : -1;
      for (int k = 0; k < NREQ; k++) begin
         if (r[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_update(input int pick, input logic [NREQ-1:0] l);
      if (pick >= 0) begin
         m_owner  = pick;
         m_locked = l[pick];
         if (!l[pick]) m_rr = (pick + 1) % NREQ;
      end else if (m_locked) begin
         m_locked = 0;
         m_rr = (m_owner + 1) % NREQ;
      end
   endtask

   // One bus cycle: apply inputs, check grant and port mux at the falling
   // edge, record expected read returns, then advance to just past the edge.
   task automatic drive_cycle(input logic rst_v, input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                              output logic [NREQ-1:0] g, output logic [NREQ-1:0] rv,
                              output logic [31:0] rd);
      int pick;
      logic [NREQ-1:0] eg;
      if (rst_v && !rst) sb.delete();
      rst = rst_v;
      if (rst_v) model_reset();
      bus.req  = r;
      bus.lock = l;
      for (int i = 0; i < NREQ; i++) begin
         bus.addr[32*i +: 32] = t_addr[i];
         bus.we[4*i +: 4]     = t_we[i];
         bus.din[32*i +: 32]  = t_din[i];
      end
      @(negedge clk);
      pick = rst_v ? -1 : model_pick(r);
      eg = '0;
      if (pick >= 0) eg[pick] = 1'b1;
      g  = bus.gnt;
      rv = bus.rvalid;
      rd = bus.rdata;
      chk("gnt", g, eg);
      chk("bram_en", BRAM_EN, pick >= 0);
      if (pick >= 0) begin
         chk("bram_addr", BRAM_ADDR, t_addr[pick]);
         chk("bram_we", BRAM_WE, t_we[pick]);
         chk("bram_din", BRAM_DIN, t_din[pick]);
         if (t_we[pick] == 4'b0000) begin
            sb.push_back('{pick, ref_mem[t_addr[pick][7:2]], cyc + READ_LAT});
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (t_we[pick][b]) ref_mem[t_addr[pick][7:2]][8*b +: 8] = t_din[pick][8*b +: 8];
            end
         end
      end else begin
         chk("bram_idle", {BRAM_WE, BRAM_ADDR, BRAM_DIN}, '0);
      end
      if (!rst_v) model_update(pick, l);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every returned read must match the oldest outstanding
   // expectation, arriving exactly on its due cycle.
   always @(negedge clk) begin
      if (rst) begin
         chk("rvalid_in_reset", bus.rvalid, '0);
      end else begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("read_missing_due", sb[0].due, cyc);
            void'(sb.pop_front());
         end
         if (bus.rvalid != '0 || (sb.size() > 0 && sb[0].due == cyc)) begin
            if (sb.size() == 0 || sb[0].due != cyc) begin
               chk("rvalid_unexpected", bus.rvalid, '0);
            end else begin
               exp_t e;
               logic [NREQ-1:0] oh;
               e = sb.pop_front();
               oh = '0;
               oh[e.id] = 1'b1;
               chk("rvalid_id", bus.rvalid, oh);
               chk("rdata", bus.rdata, e.data);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic set_slot(input int i, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      t_addr[i] = a;
      t_we[i]   = w;
      t_din[i]  = d;
   endtask

   task automatic new_txn(input int i);
      t_addr[i] = {24'd0, 4'($urandom_range(0, 15)), 2'b00};
      t_we[i]   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      t_din[i]  = $urandom;
   endtask

   initial begin
      logic [NREQ-1:0] g, rv;
      logic [31:0] rd;
      logic [2:0] rr_seq [6];
      rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

      for (int k = 0; k < 64; k++) begin
         bram_mem[k] = 32'hA500_0000 | k;
         ref_mem[k]  = 32'hA500_0000 | k;
      end
      bram_mem[4] = 32'hDEAD_BEEF;
      ref_mem[4]  = 32'hDEAD_BEEF;
      for (int i = 0; i < NREQ; i++) set_slot(i, 32'h0, 4'h0, 32'h0);
      model_reset();
      bus.req = '0; bus.lock = '0; bus.addr = '0; bus.we = '0; bus.din = '0;
      @(posedge clk); #1;

      // T1: reset with all requesting
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b1, 3'b111, 3'b000, g, rv, rd);
         chk("t1_gnt_reset", g, 3'b000);
      end
      chk("bram_rst", BRAM_RST, 1'b0);

      // T2: round-robin rotation from a fresh reset
      for (int k = 0; k < 6; k++) begin
         drive_cycle(1'b0, 3'b111, 3'b000, g, rv, rd);
         chk("t2_rr_seq", g, rr_seq[k]);
      end

      // T3: read latency and back-to-back reads
      set_slot(0, 32'h10, 4'h0, 32'h0);
      drive_cycle(1'b0, 3'b001, 3'b000, g, rv, rd);
      set_slot(0, 32'h14, 4'h0, 32'h0);
      drive_cycle(1'b0, 3'b001, 3'b000, g, rv, rd);
      chk("t3_rvalid0", rv, 3'b001);
      chk("t3_rdata0", rd, 32'hDEAD_BEEF);
      drive_cycle(1'b0, 3'b000, 3'b000, g, rv, rd);
      chk("t3_rvalid1", rv, 3'b001);
      chk("t3_rdata1", rd, 32'hA500_0005);

      // T4: burst lock by requester 1, then release with one idle cycle
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b0, 3'b111, 3'b010, g, rv, rd);
         chk("t4_locked_gnt", g, 3'b010);
      end
      drive_cycle(1'b0, 3'b101, 3'b000, g, rv, rd);
      chk("t4_idle", g, 3'b000);
      drive_cycle(1'b0, 3'b101, 3'b000, g, rv, rd);
      chk("t4_after_lock", g, 3'b100);

      // T5: partial write then readback
      set_slot(2, 32'h20, 4'b0011, 32'h1234_5678);
      drive_cycle(1'b0, 3'b100, 3'b000, g, rv, rd);
      chk("t5_we", BRAM_WE, 4'b0011);
      set_slot(2, 32'h20, 4'b0000, 32'h0);
      drive_cycle(1'b0, 3'b100, 3'b000, g, rv, rd);
      chk("t5_no_rvalid_write", rv, 3'b000);
      drive_cycle(1'b0, 3'b000, 3'b000, g, rv, rd);
      chk("t5_readback", rd[15:0], 16'h5678);

      // T6: reset right after a locked read grant
      set_slot(1, 32'h0, 4'h0, 32'h0);
      drive_cycle(1'b0, 3'b010, 3'b010, g, rv, rd);
      chk("t6_gnt", g, 3'b010);
      drive_cycle(1'b1, 3'b010, 3'b010, g, rv, rd);
      chk("t6_no_rvalid", rv, 3'b000);
      drive_cycle(1'b1, 3'b000, 3'b000, g, rv, rd);
      drive_cycle(1'b0, 3'b111, 3'b000, g, rv, rd);
      chk("t6_after_reset", g, 3'b001);

      // Random traffic: fields held until granted, req/lock free-running
      for (int i = 0; i < NREQ; i++) new_txn(i);
      for (int n = 0; n < 400; n++) begin
         logic [NREQ-1:0] r, l;
         for (int i = 0; i < NREQ; i++) begin
            r[i] = ($urandom_range(0, 3) != 0);
            l[i] = ($urandom_range(0, 7) == 0);
         end
         drive_cycle(1'b0, r, l, g, rv, rd);
         for (int i = 0; i < NREQ; i++) if (g[i]) new_txn(i);
      end

      for (int k = 0; k < READ_LAT + 2; k++) drive_cycle(1'b0, 3'b000, 3'b000, g, rv, rd);
      chk("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
